change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have the following ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  single system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to pay out change; sampled in IDLE only.
- credit  in  4  credit held, quarter units: 0..8 = 0.00..2.00; 9 = invalid; 15 = wait_pulse_down.
- price  in  4  product price, quarter units 0..8.
- coin_ack  in  1  payout mechanism accepted the presented coin.
- coin_out  out  3  coin being dispensed: 1 = 0.25, 2 = 0.50, 4 = 1.00, 0 = none.
- coin_valid  out  1  coin_out is valid and is held until acknowledged.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when payout completes normally.
- error  out  1  one-cycle pulse when a request is rejected.
- remaining  out  4  change still owed, quarter units.

Function
REQ-002 SHALL implement the states IDLE, CHECK, SELECT, PRESENT, GAP, FINISH and REJECT.
REQ-003 In IDLE, start=1 SHALL register credit and price and move to CHECK on the next edge.
REQ-004 CHECK SHALL go to REJECT if the registered credit > 8, or price > 8, or credit < price.
REQ-005 Otherwise CHECK SHALL load remaining = credit - price (4-bit, no wrap possible) and go to SELECT.
REQ-006 In SELECT, remaining = 0 SHALL go to FINISH; otherwise it SHALL choose the coin greedily and go to PRESENT:
- remaining >= 4: coin 4
- else remaining >= 2: coin 2
- else: coin 1
REQ-007 In PRESENT, coin_valid SHALL be 1 and coin_out SHALL be held stable until the cycle in which coin_ack=1.
REQ-008 On coin_ack in PRESENT, remaining SHALL decrease by the coin value (1, 2 or 4) and the FSM SHALL go to GAP.
REQ-009 GAP SHALL last exactly one cycle with coin_valid=0 and coin_out=0, then go to SELECT.
REQ-010 FINISH SHALL pulse done for one cycle and return to IDLE.
REQ-011 REJECT SHALL pulse error for one cycle, leave remaining unchanged and return to IDLE.
REQ-012 coin_ack outside PRESENT SHALL be ignored.
REQ-013 start outside IDLE SHALL be ignored; a request is never queued.
REQ-014 credit and price SHALL be sampled only on the accepting edge; later changes do not affect the payout in progress.
REQ-015 Latency:
- zero change: start to done = 3 cycles (CHECK, SELECT, FINISH).
- each coin: at least 3 cycles (SELECT, PRESENT, GAP), plus ack wait.
REQ-016 The coin count SHALL be minimal; the maximum is 3 coins (8 -> 4 + 2 + 1 is impossible; 7 = 4 + 2 + 1).
REQ-017 done and error SHALL never be high in the same cycle.
REQ-018 coin_valid SHALL never be high outside PRESENT.

Reset
REQ-019 While rst_n=0, independent of clk, the block SHALL be forced to:
- state IDLE
- coin_out = 0, coin_valid = 0, busy = 0, done = 0, error = 0, remaining = 0
REQ-020 Reset asserted mid-payout SHALL abort immediately. coin_valid drops without an ack and no done pulse is issued.
REQ-021 After rst_n rises, the first start SHALL be accepted no earlier than the first rising clk edge.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- credit=8 (2.00), price=1, start, ack 1 cycle after each valid -> coins 4, 2, 1 in order; remaining 7 -> 3 -> 1 -> 0; one done pulse.
- credit=3, price=3, start -> no coin_valid; done pulse 3 cycles after start.
- credit=2, price=5, start -> error pulse; done never; coin_valid never; remaining = 0.
- credit=9 (invalid) or credit=15, price=0, start -> error pulse.
- credit=6, price=0, coin_ack withheld 10 cycles -> coin_out=4 and coin_valid held stable for all 10 cycles; after ack, GAP cycle, then coin 2; done.
- credit=8, price=0, rst_n pulsed low during the first PRESENT -> all outputs 0 asynchronously; IDLE after release; a new start with credit=1, price=0 -> single coin 1, done.

Source files
------------

// File: rtl/change_dispenser_if.sv
// Request/payout bundle between the vending controller and the change dispenser.
// The master side issues requests and acknowledges coins.
interface change_dispenser_if;
  logic       start;
  logic [3:0] credit;
  logic [3:0] price;
  logic       coin_ack;
  logic [2:0] coin_out;
  logic       coin_valid;
  logic       busy;
  logic       done;
  logic       error;
  logic [3:0] remaining;

  modport master (
    output start, credit, price, coin_ack,
    input  coin_out, coin_valid, busy,
    input  done, error, remaining
  );

  modport slave (
    input  start, credit, price, coin_ack,
    output coin_out, coin_valid, busy,
    output done, error, remaining
  );
endinterface

// File: rtl/change_dispenser.sv
// Greedy change dispenser: pays credit - price in quarters using
// 1.00 / 0.50 / 0.25 coins, one acknowledged coin at a time.
module change_dispenser (
  input  logic             clk,
  input  logic             rst_n,
  change_dispenser_if.slave io
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SELECT,
    PRESENT,
    GAP,
    FINISH,
    REJECT
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] credit_q, credit_d;
  logic [3:0] price_q, price_d;
  logic [3:0] rem_q, rem_d;
  logic [2:0] coin_q, coin_d;

  logic bad;
  logic big;
  logic mid;

  assign bad = (credit_q > 4'd8) ||
               (price_q > 4'd8) ||
               (credit_q < price_q);

  // Mutually exclusive greedy tiers so the decoder stays unique.
  assign big = |rem_q[3:2];
  assign mid = ~big & rem_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      credit_q <= '0;
      price_q  <= '0;
      rem_q    <= '0;
      coin_q   <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      price_q  <= price_d;
      rem_q    <= rem_d;
      coin_q   <= coin_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    price_d  = price_q;
    rem_d    = rem_q;
    coin_d   = coin_q;
    unique case (state_q)
      IDLE: begin
        if (io.start) begin
          credit_d = io.credit;
          price_d  = io.price;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        if (bad) begin
          state_d = REJECT;
        end else begin
          rem_d   = credit_q - price_q;
          state_d = SELECT;
        end
      end
      SELECT: begin
        if (rem_q == 4'd0) begin
          state_d = FINISH;
        end else begin
          state_d = PRESENT;
          unique case (1'b1)
            big:     coin_d = 3'd4;
            mid:     coin_d = 3'd2;
            default: coin_d = 3'd1;
          endcase
        end
      end
      PRESENT: begin
        if (io.coin_ack) begin
          rem_d   = rem_q - {1'b0, coin_q};
          state_d = GAP;
        end
      end
      GAP:     state_d = SELECT;
      FINISH:  state_d = IDLE;
      REJECT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    io.busy       = (state_q != IDLE);
    io.coin_valid = (state_q == PRESENT);
    io.coin_out   = (state_q == PRESENT) ? coin_q : 3'd0;
    io.done       = (state_q == FINISH);
    io.error      = (state_q == REJECT);
    io.remaining  = rem_q;
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: vector table plus
// hand-written reset-abort and ignored-input sequences.
module tb_change_dispenser;

  logic clk = 1'b0;
  logic rst_n;

  change_dispenser_if io();

  change_dispenser dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (io)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] credit;
    logic [3:0] price;
    int         dly;
    int         exp_err;
    int         exp_n;
    int         c0;
    int         c1;
    int         c2;
    int         lat;
  } vec_t;

  vec_t vecs[12];

  int got_n;
  int got_done;
  int got_err;
  int end_at;
  int got_c[3];

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_coin_out"},   io.coin_out,   0);
    chk({tag, "_coin_valid"}, io.coin_valid, 0);
    chk({tag, "_busy"},       io.busy,       0);
    chk({tag, "_done"},       io.done,       0);
    chk({tag, "_error"},      io.error,      0);
    chk({tag, "_remaining"},  io.remaining,  0);
  endtask

  // One request from IDLE; called at a sample point (#1 after an edge).
  task automatic run(input logic [3:0] cr, input logic [3:0] pr,
                     input int dly, input bit poke);
    int wcnt;
    int rem_m;
    int cur;
    bit ackd;
    bit fin;
    got_n    = 0;
    got_done = 0;
    got_err  = 0;
    end_at   = -1;
    got_c    = '{0, 0, 0};
    wcnt     = 0;
    cur      = 0;
    ackd     = 0;
    fin      = 0;
    if (cr <= 4'd8 && pr <= 4'd8 && cr >= pr)
      rem_m = int'(cr) - int'(pr);
    else
      rem_m = 0;
    io.credit = cr;
    io.price  = pr;
    io.start  = 1'b1;
    @(posedge clk); #1;
    io.start = 1'b0;
    chk("busy_after_start", io.busy, 1);
    if (poke) begin
      io.credit = 4'd0;
      io.price  = 4'd8;
    end
    for (int c = 0; c < 200 && !fin; c++) begin
      @(posedge clk); #1;
      io.coin_ack = 1'b0;
      if (ackd) begin
        chk("gap_valid", io.coin_valid, 0);
        chk("gap_coin", io.coin_out, 0);
        chk("gap_remaining", io.remaining, rem_m);
        ackd = 0;
      end
      chk("done_and_error", io.done & io.error, 0);
      if (io.done || io.error) begin
        fin      = 1;
        end_at   = c;
        got_done += int'(io.done);
        got_err  += int'(io.error);
      end
      if (io.coin_valid) begin
        if (wcnt == 0) begin
          if (got_n < 3) got_c[got_n] = int'(io.coin_out);
          got_n++;
          cur = int'(io.coin_out);
        end else begin
          chk("coin_stable", io.coin_out, cur);
        end
        wcnt++;
        if (wcnt > dly) begin
          io.coin_ack = 1'b1;
          wcnt  = 0;
          rem_m -= cur;
          ackd  = 1;
        end
      end else if (poke && !fin) begin
        io.coin_ack = 1'b1;
      end
      if (poke) io.start = !fin;
    end
    io.start    = 1'b0;
    io.coin_ack = 1'b0;
    io.credit   = 4'd0;
    io.price    = 4'd0;
    chk("timeout", fin, 1);
    chk("remaining_final", io.remaining, rem_m);
    @(posedge clk); #1;
    chk("pulse_one_cycle", io.done | io.error, 0);
    chk("idle_busy", io.busy, 0);
  endtask

  initial begin
    rst_n       = 1'b1;
    io.start    = 1'b0;
    io.credit   = 4'd0;
    io.price    = 4'd0;
    io.coin_ack = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk_outputs_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_busy", io.busy, 0);

    //          cr     pr    dly err n  c0 c1 c2 lat
    vecs[0]  = '{4'd8, 4'd1, 1,  0, 3, 4, 2, 1, -1};
    vecs[1]  = '{4'd3, 4'd3, 0,  0, 0, 0, 0, 0,  1};
    vecs[2]  = '{4'd2, 4'd5, 0,  1, 0, 0, 0, 0,  0};
    vecs[3]  = '{4'd9, 4'd0, 0,  1, 0, 0, 0, 0,  0};
    vecs[4]  = '{4'd15,4'd0, 0,  1, 0, 0, 0, 0,  0};
    vecs[5]  = '{4'd6, 4'd0, 10, 0, 2, 4, 2, 0, -1};
    vecs[6]  = '{4'd5, 4'd0, 0,  0, 2, 4, 1, 0, -1};
    vecs[7]  = '{4'd8, 4'd0, 2,  0, 2, 4, 4, 0, -1};
    vecs[8]  = '{4'd4, 4'd9, 0,  1, 0, 0, 0, 0,  0};
    vecs[9]  = '{4'd8, 4'd8, 0,  0, 0, 0, 0, 0,  1};
    vecs[10] = '{4'd6, 4'd3, 0,  0, 2, 2, 1, 0, -1};
    vecs[11] = '{4'd2, 4'd0, 0,  0, 1, 2, 0, 0, -1};

    for (int i = 0; i < 12; i++) begin
      vec_t v;
      v = vecs[i];
      run(v.credit, v.price, v.dly, 1'b0);
      chk($sformatf("v%0d_ncoins", i), got_n, v.exp_n);
      chk($sformatf("v%0d_coin0", i), got_c[0], v.c0);
      chk($sformatf("v%0d_coin1", i), got_c[1], v.c1);
      chk($sformatf("v%0d_coin2", i), got_c[2], v.c2);
      chk($sformatf("v%0d_error", i), got_err, v.exp_err);
      chk($sformatf("v%0d_done", i), got_done, 1 - v.exp_err);
      if (v.lat >= 0)
        chk($sformatf("v%0d_latency", i), end_at, v.lat);
    end

    // Reset in the middle of the first coin presentation.
    io.credit = 4'd8;
    io.price  = 4'd0;
    io.start  = 1'b1;
    @(posedge clk); #1;
    io.start = 1'b0;
    for (int c = 0; c < 10 && !io.coin_valid; c++) begin
      @(posedge clk); #1;
    end
    chk("abort_valid_before", io.coin_valid, 1);
    chk("abort_coin_before", io.coin_out, 4);
    #2 rst_n = 1'b0;
    #1;
    chk_outputs_zero("abort");
    @(posedge clk); #1;
    chk("abort_held_done", io.done, 0);
    chk("abort_held_busy", io.busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_idle_busy", io.busy, 0);
    chk("abort_idle_rem", io.remaining, 0);
    run(4'd1, 4'd0, 0, 1'b0);
    chk("after_abort_ncoins", got_n, 1);
    chk("after_abort_coin0", got_c[0], 1);
    chk("after_abort_done", got_done, 1);

    // start, credit/price changes and stray acks while busy are ignored.
    run(4'd5, 4'd0, 1, 1'b1);
    chk("poke_ncoins", got_n, 2);
    chk("poke_coin0", got_c[0], 4);
    chk("poke_coin1", got_c[1], 1);
    chk("poke_done", got_done, 1);
    chk("poke_error", got_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
